// File: rtl/l2_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : l2_bus_responder                                                  |
// | Brief  : Behavioural L2 slave with fixed access latency, FREE/BUSY/ACCESS/ |
// |          ERROR status and a non-reset word-addressed backing array.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module l2_bus_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        l2REN,
    input  logic        l2WEN,
    input  logic [31:0] l2addr,
    input  logic [31:0] l2store,
    output logic [31:0] l2load,
    output logic [1:0]  l2state
);

    localparam int c_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    l2_state_t          r_state;
    l2_state_t          w_next_state;
    logic [3:0]         r_cnt;
    logic               r_is_write;
    logic [c_IDX_W-1:0] r_idx;
    logic [31:0]        r_store;
    logic [31:0]        r_mem [MEM_WORDS];

    logic               w_req;
    logic               w_req_err;
    logic               w_accept;
    logic               w_commit;
    logic               w_acc_write;
    logic [c_IDX_W-1:0] w_acc_idx;
    logic [31:0]        w_acc_store;

    assign w_req     = l2REN | l2WEN;
    assign w_req_err = (l2REN & l2WEN)
                     | (l2addr[1:0] != 2'b00)
                     | ({2'b00, l2addr[31:2]} >= 32'(MEM_WORDS));
    assign w_accept  = (r_state == L2_FREE) && w_req && !w_req_err;

    // With LATENCY=1 the commit happens on the accepting edge, so the live
    // request fields are used instead of the (not yet loaded) latches.
    assign w_acc_write = (r_state == L2_FREE) ? l2WEN   : r_is_write;
    assign w_acc_idx   = (r_state == L2_FREE) ? l2addr[c_IDX_W+1:2] : r_idx;
    assign w_acc_store = (r_state == L2_FREE) ? l2store : r_store;
    assign w_commit    = (w_next_state == L2_ACCESS);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= L2_FREE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            L2_FREE: begin
                if (w_req) begin
                    if (w_req_err) begin
                        w_next_state = L2_ERROR;
                    end else if (LATENCY == 1) begin
                        w_next_state = L2_ACCESS;
                    end else begin
                        w_next_state = L2_BUSY;
                    end
                end
            end
            L2_BUSY: begin
                if (!w_req) begin
                    w_next_state = L2_FREE;
                end else if (r_cnt == 4'd1) begin
                    w_next_state = L2_ACCESS;
                end
            end
            L2_ACCESS: w_next_state = L2_FREE;
            L2_ERROR:  w_next_state = L2_FREE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt      <= 4'd0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_store    <= 32'd0;
            l2load     <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt      <= 4'(LATENCY - 1);
                r_is_write <= l2WEN;
                r_idx      <= l2addr[c_IDX_W+1:2];
                r_store    <= l2store;
            end else if ((r_state == L2_BUSY) && (r_cnt > 4'd1)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !w_acc_write) begin
                l2load <= r_mem[w_acc_idx];
            end
        end
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (w_commit && w_acc_write) begin
            r_mem[w_acc_idx] <= w_acc_store;
        end
    end

    assign l2state = r_state;

endmodule
`default_nettype wire
